// File: rtl/id_opnd_stage.sv
// ID/EX operand stage: resolves source operands through a priority forwarding
// network, detects load-use hazards against the youngest source, and registers ID/EX.
module id_opnd_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 30,
  parameter int N_FWD  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    if_en,
  input  logic [PC_W-1:0]         if_pc,
  input  logic [ADDR_W-1:0]       rs0_addr,
  input  logic [ADDR_W-1:0]       rs1_addr,
  input  logic                    rs0_use,
  input  logic                    rs1_use,
  input  logic [DATA_W-1:0]       gpr_rd_data_0,
  input  logic [DATA_W-1:0]       gpr_rd_data_1,
  input  logic [N_FWD-1:0]        fwd_en,
  input  logic [N_FWD-1:0]        fwd_gpr_we_,
  input  logic [N_FWD-1:0]        fwd_is_load,
  input  logic [N_FWD*ADDR_W-1:0] fwd_dst_addr,
  input  logic [N_FWD*DATA_W-1:0] fwd_data,
  output logic                    ld_hazard,
  output logic                    id_en,
  output logic [PC_W-1:0]         id_pc,
  output logic [DATA_W-1:0]       id_opnd_0,
  output logic [DATA_W-1:0]       id_opnd_1,
  output logic [CNT_W-1:0]        hazard_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [N_FWD-1:0]  w_hit0_p0, w_hit1_p0;
  logic [DATA_W-1:0] w_opnd0_p0, w_opnd1_p0;

  // Stage p0: match forwarding sources and resolve operands
  always_comb begin
    for (int i = 0; i < N_FWD; i++) begin
      w_hit0_p0[i] = fwd_en[i] & ~fwd_gpr_we_[i] &
                     (fwd_dst_addr[i*ADDR_W +: ADDR_W] == rs0_addr);
      w_hit1_p0[i] = fwd_en[i] & ~fwd_gpr_we_[i] &
                     (fwd_dst_addr[i*ADDR_W +: ADDR_W] == rs1_addr);
    end
  end

  // Walk from oldest to youngest so the lowest-index match is the final winner.
  always_comb begin
    w_opnd0_p0 = gpr_rd_data_0;
    w_opnd1_p0 = gpr_rd_data_1;
    for (int i = N_FWD-1; i >= 0; i--) begin
      if (w_hit0_p0[i]) w_opnd0_p0 = fwd_data[i*DATA_W +: DATA_W];
      if (w_hit1_p0[i]) w_opnd1_p0 = fwd_data[i*DATA_W +: DATA_W];
    end
  end

  // Only the EX source can still be waiting on memory; older loads are forwardable.
  assign ld_hazard = if_en & fwd_is_load[0] &
                     ((rs0_use & w_hit0_p0[0]) | (rs1_use & w_hit1_p0[0]));

  logic              r_vld_p1;
  logic [PC_W-1:0]   r_pc_p1;
  logic [DATA_W-1:0] r_opnd0_p1, r_opnd1_p1;
  logic [CNT_W-1:0]  r_cnt_p1;

  // Stage p1: ID/EX register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_pc_p1    <= '0;
      r_opnd0_p1 <= '0;
      r_opnd1_p1 <= '0;
      r_cnt_p1   <= '0;
    end else if (flush) begin
      r_vld_p1   <= 1'b0;
      r_pc_p1    <= '0;
      r_opnd0_p1 <= '0;
      r_opnd1_p1 <= '0;
    end else if (!stall) begin
      if (ld_hazard) begin
        r_vld_p1 <= 1'b0;
        r_cnt_p1 <= sat_inc(r_cnt_p1);
      end else begin
        r_vld_p1   <= if_en;
        r_pc_p1    <= if_pc;
        r_opnd0_p1 <= w_opnd0_p0;
        r_opnd1_p1 <= w_opnd1_p0;
      end
    end
  end

  assign id_en      = r_vld_p1;
  assign id_pc      = r_pc_p1;
  assign id_opnd_0  = r_opnd0_p1;
  assign id_opnd_1  = r_opnd1_p1;
  assign hazard_cnt = r_cnt_p1;

endmodule

// File: tb/tb_id_opnd_stage.sv
// Randomized self-checking bench for id_opnd_stage against a priority-rule model,
// plus directed checks of forwarding, hazards, stall/flush and counter saturation.
module tb_id_opnd_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush, if_en;
  logic [29:0] if_pc;
  logic [4:0]  rs0, rs1;
  logic        rs0_use, rs1_use;
  logic [31:0] gpr0, gpr1;
  logic [1:0]  f_en, f_we_n, f_ld;
  logic [4:0]  f_dst [2];
  logic [31:0] f_data [2];
  logic [9:0]  w_dst_pk;
  logic [63:0] w_data_pk;

  logic        ld_hazard, id_en, ld_hazard4, id_en4;
  logic [29:0] id_pc, id_pc4;
  logic [31:0] id_opnd_0, id_opnd_1, id_opnd_04, id_opnd_14;
  logic [15:0] hazard_cnt;
  logic [3:0]  hazard_cnt4;

  int n_chk = 0;
  int n_fail = 0;

  assign w_dst_pk  = {f_dst[1], f_dst[0]};
  assign w_data_pk = {f_data[1], f_data[0]};

  always #5 clk = ~clk;

  id_opnd_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .if_en(if_en), .if_pc(if_pc),
    .rs0_addr(rs0), .rs1_addr(rs1), .rs0_use(rs0_use), .rs1_use(rs1_use),
    .gpr_rd_data_0(gpr0), .gpr_rd_data_1(gpr1), .fwd_en(f_en), .fwd_gpr_we_(f_we_n),
    .fwd_is_load(f_ld), .fwd_dst_addr(w_dst_pk), .fwd_data(w_data_pk),
    .ld_hazard(ld_hazard), .id_en(id_en), .id_pc(id_pc), .id_opnd_0(id_opnd_0),
    .id_opnd_1(id_opnd_1), .hazard_cnt(hazard_cnt));

  id_opnd_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .if_en(if_en), .if_pc(if_pc),
    .rs0_addr(rs0), .rs1_addr(rs1), .rs0_use(rs0_use), .rs1_use(rs1_use),
    .gpr_rd_data_0(gpr0), .gpr_rd_data_1(gpr1), .fwd_en(f_en), .fwd_gpr_we_(f_we_n),
    .fwd_is_load(f_ld), .fwd_dst_addr(w_dst_pk), .fwd_data(w_data_pk),
    .ld_hazard(ld_hazard4), .id_en(id_en4), .id_pc(id_pc4), .id_opnd_0(id_opnd_04),
    .id_opnd_1(id_opnd_14), .hazard_cnt(hazard_cnt4));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic        m_valid = 1'b0;
  logic        m_en;
  logic [29:0] m_pc;
  logic [31:0] m_op0, m_op1;
  int          m_cnt, m_cnt4;

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] g);
    for (int i = 0; i < 2; i++)
      if (f_en[i] && !f_we_n[i] && f_dst[i] == a) return f_data[i];
    return g;
  endfunction

  function automatic logic exp_haz();
    logic ex_load;
    ex_load = f_en[0] && !f_we_n[0] && f_ld[0];
    return if_en && ex_load && ((rs0_use && f_dst[0] == rs0) || (rs1_use && f_dst[0] == rs1));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_en = 0; m_pc = 0; m_op0 = 0; m_op1 = 0; m_cnt = 0; m_cnt4 = 0; m_valid = 1;
    end else if (flush) begin
      m_en = 0; m_pc = 0; m_op0 = 0; m_op1 = 0;
    end else if (!stall) begin
      if (exp_haz()) begin
        m_en = 0;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end else begin
        m_en = if_en; m_pc = if_pc; m_op0 = resolve(rs0, gpr0); m_op1 = resolve(rs1, gpr1);
      end
    end
  end

  always @(negedge clk) begin
    chk("ld_hazard", ld_hazard, exp_haz());
    if (m_valid) begin
      chk("id_en", id_en, m_en);
      chk("id_pc", id_pc, m_pc);
      chk("id_opnd_0", id_opnd_0, m_op0);
      chk("id_opnd_1", id_opnd_1, m_op1);
      chk("hazard_cnt", hazard_cnt, 64'(m_cnt));
      chk("hazard_cnt4", hazard_cnt4, 64'(m_cnt4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; if_en = 0; if_pc = 0; rs0 = 0; rs1 = 0; rs0_use = 0; rs1_use = 0;
    gpr0 = 0; gpr1 = 0; f_en = 0; f_we_n = 0; f_ld = 0;
    f_dst[0] = 0; f_dst[1] = 0; f_data[0] = 0; f_data[1] = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic set_ex_load_hazard();
    if_en = 1; rs1 = 11; rs1_use = 1; rs0 = 2; rs0_use = 0;
    f_en = 2'b01; f_we_n = 2'b00; f_ld = 2'b01; f_dst[0] = 11; f_dst[1] = 7;
  endtask

  initial begin
    reset = 1;
    idle();
    tick(); tick();
    chk("reset_en", id_en, 0);
    chk("reset_cnt", hazard_cnt, 0);
    reset = 0;

    if_en = 1; if_pc = 1000; rs0 = 11; rs0_use = 1; gpr0 = 32'h1234;
    rs1 = 3; gpr1 = 32'h5678;
    f_en = 2'b11; f_dst[0] = 11; f_dst[1] = 11; f_data[0] = 32'hAAAA; f_data[1] = 32'hBBBB;
    tick();
    chk("fwd_src0", id_opnd_0, 32'hAAAA);
    chk("fwd_en", id_en, 1);
    chk("fwd_pc", id_pc, 1000);
    chk("gpr_opnd1", id_opnd_1, 32'h5678);
    f_en = 2'b10;
    tick();
    chk("fwd_src1", id_opnd_0, 32'hBBBB);
    f_en = 2'b00;
    tick();
    chk("no_match", id_opnd_0, 32'h1234);

    if_pc = 1004;
    set_ex_load_hazard();
    #1 chk("haz_comb", ld_hazard, 1);
    tick();
    chk("haz_bubble", id_en, 0);
    chk("haz_pc_hold", id_pc, 1000);
    chk("haz_cnt1", hazard_cnt, 1);
    rs1_use = 0;
    #1 chk("haz_unused", ld_hazard, 0);
    rs1_use = 1; f_en = 2'b10; f_ld = 2'b10; f_dst[1] = 11;
    #1 chk("haz_old_load", ld_hazard, 0);

    do_reset();
    set_ex_load_hazard();
    repeat (20) tick();
    chk("sat_cnt4", hazard_cnt4, 15);
    chk("cnt16_20", hazard_cnt, 20);

    idle(); if_en = 1; if_pc = 77; gpr0 = 32'hCAFE;
    tick();
    chk("pre_stall_en", id_en, 1);
    set_ex_load_hazard(); if_pc = 99; stall = 1;
    repeat (200) tick();
    chk("stall_pc", id_pc, 77);
    chk("stall_en", id_en, 1);
    chk("stall_cnt", hazard_cnt, 20);
    chk("stall_haz", ld_hazard, 1);
    stall = 0; flush = 1;
    repeat (200) tick();
    chk("flush_pc", id_pc, 0);
    chk("flush_cnt", hazard_cnt, 20);
    stall = 1;
    repeat (200) tick();
    chk("both_en", id_en, 0);
    chk("both_cnt", hazard_cnt, 20);

    idle(); if_en = 1; if_pc = 55; gpr1 = 32'hBEEF;
    tick();
    stall = 1;
    tick();
    chk("mid_stall_en", id_en, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_stall_en", id_en, 0);
    chk("rst_stall_pc", id_pc, 0);
    chk("rst_stall_op1", id_opnd_1, 0);

    for (int n = 0; n < 500; n++) begin
      reset   = ($urandom_range(0, 49) == 0);
      stall   = ($urandom_range(0, 7) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      if_en   = $urandom_range(0, 1);
      if_pc   = 30'($urandom);
      rs0     = 5'($urandom_range(0, 3));
      rs1     = 5'($urandom_range(0, 3));
      rs0_use = $urandom_range(0, 1);
      rs1_use = $urandom_range(0, 1);
      gpr0    = $urandom;
      gpr1    = $urandom;
      f_en    = 2'($urandom);
      f_we_n  = 2'($urandom);
      f_ld    = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        f_dst[i]  = 5'($urandom_range(0, 3));
        f_data[i] = $urandom;
      end
      tick();
    end
    reset = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_opnd_stage.md
ID_OPND_STAGE -- requirements
Module: id_opnd_stage

Interface
REQ-001 Parameter DATA_W, 32, operand/data width in bits.
REQ-002 Parameter ADDR_W, 5, GPR address width.
REQ-003 Parameter PC_W, 30, word-address program counter width.
REQ-004 Parameter N_FWD, 2, number of forwarding sources; index 0 = EX (youngest), N_FWD-1 = oldest; N_FWD >= 1.
REQ-005 Parameter CNT_W, 16, hazard counter width.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 stall  in  1  hold ID/EX register.
REQ-010 flush  in  1  squash ID/EX register.
REQ-011 if_en  in  1  IF/ID entry valid.
REQ-012 if_pc  in  PC_W  IF/ID program counter.
REQ-013 rs0_addr, rs1_addr  in  ADDR_W each  source register addresses.
REQ-014 rs0_use, rs1_use  in  1 each  source actually read by instruction.
REQ-015 gpr_rd_data_0, gpr_rd_data_1  in  DATA_W each  register file read data.
REQ-016 fwd_en  in  N_FWD  per-source pipeline valid.
REQ-017 fwd_gpr_we_  in  N_FWD  per-source GPR write enable, active-low.
REQ-018 fwd_is_load  in  N_FWD  per-source result comes from memory load.
REQ-019 fwd_dst_addr  in  N_FWD*ADDR_W  packed destinations, source i at [i*ADDR_W +: ADDR_W].
REQ-020 fwd_data  in  N_FWD*DATA_W  packed forwarding data, same packing.
REQ-021 ld_hazard  out  1  combinational load-use hazard.
REQ-022 id_en, id_pc, id_opnd_0, id_opnd_1  out  1/PC_W/DATA_W/DATA_W  registered ID/EX outputs.
REQ-023 hazard_cnt  out  CNT_W  registered count of hazard bubbles.

Function
REQ-024 Source i matches operand k when fwd_en[i]=1, fwd_gpr_we_[i]=0, fwd_dst_addr[i]=rsk_addr; register 0 is not special.
REQ-025 Operand k resolves to fwd_data of lowest-index matching source; no match -> gpr_rd_data_k.
REQ-026 ld_hazard = if_en & ((rs0_use & source 0 matches rs0 & fwd_is_load[0]) | (rs1_use & same for rs1)); fwd_is_load on sources >= 1 never causes a hazard.
REQ-027 Register update priority per edge: reset > flush > stall > ld_hazard > normal load.
REQ-028 flush: id_en, id_pc, id_opnd_0, id_opnd_1 <= 0.
REQ-029 stall (no flush): all ID/EX outputs hold.
REQ-030 ld_hazard (no flush/stall): id_en <= 0 (bubble); id_pc, id_opnd_* hold.
REQ-031 Normal: id_en <= if_en, id_pc <= if_pc, id_opnd_k <= resolved operand k; latency one cycle.
REQ-032 hazard_cnt increments on edges where ld_hazard=1, stall=0, flush=0; saturates at 2^CNT_W-1, no wrap.
REQ-033 stall and flush both high: flush wins; hazard_cnt unchanged.
REQ-034 ld_hazard output is combinational and remains asserted while stall=1; upstream holds IF/ID.

Reset
REQ-035 reset=1 at edge: id_en, id_pc, id_opnd_0, id_opnd_1, hazard_cnt <= 0, overriding stall/flush/hazard.
REQ-036 Reset mid-stall or mid-hazard discards held contents; first post-reset edge follows REQ-027.

Verification
REQ-037 N_FWD=2; if_en=1, if_pc=1000, rs0=11 used, src0 en/we_=0/dst 11/data 0xAAAA, non-load; src1 dst 11 data 0xBBBB -> next edge id_opnd_0=0xAAAA, id_en=1, id_pc=1000.
REQ-038 src0 disabled, src1 dst 11 data 0xBBBB -> id_opnd_0=0xBBBB; no match -> gpr_rd_data_0.
REQ-039 src0 load to r11, rs1=11 used -> ld_hazard=1, next edge id_en=0, id_pc held, hazard_cnt=1; rs1_use=0 -> ld_hazard=0.
REQ-040 stall=1 for 200 cycles, then flush=1 for 200, then both -> outputs hold, then all zero, then zero; hazard_cnt unchanged throughout.
REQ-041 CNT_W=4, hazard held 20 cycles -> hazard_cnt stops at 15.
REQ-042 reset=1 asserted during stall with id_en=1 -> next edge all outputs 0.
